// File: rtl/tbird_pkg.sv
// Shared mode codes and FSM encoding for the T-bird tail-light controller,
// lamp datapath and their benches.
package tbird_pkg;

  localparam logic [2:0] MODE_OFF    = 3'b000;
  localparam logic [2:0] MODE_RIGHT  = 3'b001;
  localparam logic [2:0] MODE_LEFT   = 3'b010;
  localparam logic [2:0] MODE_HAZARD = 3'b011;
  localparam int         BRAKE_BIT   = 2;

  localparam logic [1:0] CODE_OFF    = MODE_OFF[1:0];
  localparam logic [1:0] CODE_RIGHT  = MODE_RIGHT[1:0];
  localparam logic [1:0] CODE_LEFT   = MODE_LEFT[1:0];
  localparam logic [1:0] CODE_HAZARD = MODE_HAZARD[1:0];

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } tbird_state_e;

  // Both turn levels together mean the driver wants every lamp, same as hazard.
  function automatic logic [1:0] decode_req(input logic left, input logic right,
                                            input logic hazard);
    logic [1:0] code;
    code = CODE_OFF;
    if (hazard || (left && right)) code = CODE_HAZARD;
    else if (left)                 code = CODE_LEFT;
    else if (right)                code = CODE_RIGHT;
    return code;
  endfunction

endpackage

// File: rtl/tbird_step_prescaler.sv
// Lamp-step prescaler: counts clock cycles while running and emits a
// one-cycle step pulse every TICK_DIV cycles.
module tbird_step_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic step
);

  localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count;

  // Counter sits at zero when not running, so every sweep starts a full interval.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign step = run && (count == LAST_COUNT);

endmodule

// File: rtl/tbird_seq_ctrl.sv
// T-bird tail-light sequencing controller: decodes driver requests into the
// lamp mode code, paces sweeps and commits direction changes on sweep boundaries.
module tbird_seq_ctrl
  import tbird_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int SWEEP_LEN = 5,
  parameter int DIV_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake_req,
  output logic [2:0] switch,
  output logic       step,
  output logic [2:0] phase,
  output logic       busy
);

  localparam logic [2:0] LAST_PHASE = 3'(SWEEP_LEN - 1);

  tbird_state_e state, state_next;
  logic [1:0]   req_code;
  logic [1:0]   active_code, active_next;
  logic [2:0]   phase_next;
  logic         brake_q;

  assign req_code = decode_req(left_req, right_req, hazard_req);

  tbird_step_prescaler #(
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .run  (busy),
    .step (step)
  );

  always_comb begin
    state_next  = state;
    active_next = active_code;
    phase_next  = phase;
    case (state)
      ST_IDLE: begin
        if (req_code != CODE_OFF) begin
          state_next  = ST_SWEEP;
          active_next = req_code;
          phase_next  = '0;
        end else begin
          active_next = CODE_OFF;
        end
      end
      ST_SWEEP: begin
        // Requests are only looked at on a step; between steps everything holds.
        if (step) begin
          if ((req_code == CODE_HAZARD) && (active_code != CODE_HAZARD)) begin
            active_next = CODE_HAZARD;
            phase_next  = '0;
          end else if (phase == LAST_PHASE) begin
            phase_next = '0;
            if (req_code == CODE_OFF) begin
              state_next  = ST_IDLE;
              active_next = CODE_OFF;
            end else begin
              active_next = req_code;
            end
          end else begin
            phase_next = phase + 3'd1;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        active_next = CODE_OFF;
        phase_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      active_code <= CODE_OFF;
      phase       <= '0;
    end else begin
      state       <= state_next;
      active_code <= active_next;
      phase       <= phase_next;
    end
  end

  // Brake is orthogonal to the sweep: a plain one-cycle register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake_req;
    end
  end

  assign switch[BRAKE_BIT] = brake_q;
  assign switch[1:0]       = active_code;
  assign busy              = (state == ST_SWEEP);

endmodule

// File: tb/tb_tbird_seq_ctrl.sv
// Bench for tbird_seq_ctrl: directed scenarios plus randomized requests,
// all checked against a behavioural model of the sequencing rules.
module tb_tbird_seq_ctrl;

  localparam int TD = 4;
  localparam int SL = 5;

  logic       clock;
  logic       reset;
  logic       left_req, right_req, hazard_req, brake_req;
  logic [2:0] switch;
  logic       step;
  logic [2:0] phase;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: sweep status, committed code, phase, cycles into the step interval.
  bit m_busy;
  bit m_brake;
  int m_code;
  int m_phase;
  int m_cnt;

  tbird_seq_ctrl #(
    .TICK_DIV (TD),
    .SWEEP_LEN(SL),
    .DIV_W    (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .left_req  (left_req),
    .right_req (right_req),
    .hazard_req(hazard_req),
    .brake_req (brake_req),
    .switch    (switch),
    .step      (step),
    .phase     (phase),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy  = 0;
    m_brake = 0;
    m_code  = 0;
    m_phase = 0;
    m_cnt   = 0;
  endtask

  // One clock edge of the sequencing rules, applied to the current requests.
  task automatic model_step();
    int req;
    bit stp;
    if (hazard_req || (left_req && right_req)) req = 3;
    else if (left_req)                         req = 2;
    else if (right_req)                        req = 1;
    else                                       req = 0;
    stp     = m_busy && (m_cnt == TD - 1);
    m_brake = brake_req;
    if (!m_busy) begin
      m_cnt = 0;
      if (req != 0) begin
        m_busy  = 1;
        m_code  = req;
        m_phase = 0;
      end else begin
        m_code = 0;
      end
    end else begin
      m_cnt = stp ? 0 : m_cnt + 1;
      if (stp) begin
        if (req == 3 && m_code != 3) begin
          m_code  = 3;
          m_phase = 0;
        end else if (m_phase == SL - 1) begin
          m_phase = 0;
          if (req == 0) begin
            m_busy = 0;
            m_code = 0;
          end else begin
            m_code = req;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  task automatic compare();
    check_val("switch", 8'(switch), 8'((m_brake ? 4 : 0) + m_code));
    check_val("phase",  8'(phase),  8'(m_phase));
    check_val("busy",   8'(busy),   8'(m_busy));
    check_val("step",   8'(step),   8'(m_busy && (m_cnt == TD - 1)));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_clear();
    else       model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 200 && !(m_busy && m_phase == p); i++) cycle();
    check_val("wait_phase", 8'(m_busy && m_phase == p), 8'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_busy; i++) cycle();
    check_val("wait_idle", 8'(m_busy), 8'd0);
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic async_reset();
    @(posedge clock);
    model_step();
    #2;
    reset = 1'b1;
    #1;
    check_val("async_switch", 8'(switch), 8'd0);
    check_val("async_phase",  8'(phase),  8'd0);
    check_val("async_busy",   8'(busy),   8'd0);
    check_val("async_step",   8'(step),   8'd0);
    model_clear();
    @(negedge clock);
    compare();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    left_req   = 1'b0;
    right_req  = 1'b0;
    hazard_req = 1'b0;
    brake_req  = 1'b0;
    model_clear();
    repeat (2) cycle();
    right_req = 1'b1;
    repeat (5) cycle();
    reset = 1'b0;

    // Right sweep straight out of reset, two full sweeps.
    repeat (45) cycle();

    // Switch to left mid-sweep; commits only at the wrap step.
    wait_phase(2);
    right_req = 1'b0;
    left_req  = 1'b1;
    repeat (25) cycle();

    // Hazard preempts a left sweep at the next step.
    wait_phase(1);
    hazard_req = 1'b1;
    repeat (8) cycle();
    hazard_req = 1'b0;
    right_req  = 1'b1;
    repeat (30) cycle();

    // Brake pulse in idle and during a right sweep.
    left_req  = 1'b0;
    right_req = 1'b0;
    wait_idle();
    repeat (3) cycle();
    brake_req = 1'b1;
    repeat (3) cycle();
    brake_req = 1'b0;
    repeat (3) cycle();
    right_req = 1'b1;
    repeat (6) cycle();
    brake_req = 1'b1;
    repeat (3) cycle();
    brake_req = 1'b0;
    repeat (3) cycle();

    // Request drops mid-sweep: finish the sweep, then idle.
    wait_phase(3);
    right_req = 1'b0;
    repeat (30) cycle();
    check_val("idle_after_drop", 8'(busy), 8'd0);

    right_req = 1'b1;
    repeat (6) cycle();
    async_reset();
    repeat (10) cycle();

    // Randomized request traffic with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          left_req   = 1'b0;
          right_req  = 1'b0;
          hazard_req = 1'b0;
        end else begin
          left_req   = 1'($urandom_range(0, 1));
          right_req  = 1'($urandom_range(0, 1));
          hazard_req = ($urandom_range(0, 5) == 0);
        end
      end
      if ($urandom_range(0, 7) == 0) brake_req = ~brake_req;
      if ($urandom_range(0, 399) == 0) async_reset();
      else                            cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tbird_seq_ctrl.md
Name: tbird_seq_ctrl

Overview:
Sequencing controller for the T-bird tail-light lamp datapath. It turns raw driver requests (left, right, hazard, brake) into the 3-bit mode code the lamp datapath consumes. It generates the step-enable pulse that paces each sweep and tracks the sweep phase. Turn-direction changes take effect only on sweep boundaries, so a lamp sweep is never cut mid-pattern.

Parameters:
TICK_DIV, 4, clock cycles per lamp step (>=1)
SWEEP_LEN, 5, steps per sweep, phase 0..SWEEP_LEN-1 (2..8)
DIV_W, 8, prescaler counter width; must hold TICK_DIV-1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
left_req  input  1  left turn requested (level)
right_req  input  1  right turn requested (level)
hazard_req  input  1  hazard requested (level)
brake_req  input  1  brake pedal (level)
switch  output  3  mode code to lamp datapath: {brake, left, right}
step  output  1  one-cycle lamp-advance pulse
phase  output  3  current sweep phase
busy  output  1  high while in SWEEP

Behaviour:
- Single clock; reset asynchronous, active-high. All flops clear on reset assertion, not on the next edge.
- Reset values: switch=000, step=0, phase=0, busy=0, state=IDLE, prescaler=0, active_code=00, brake_q=0.
- Mode codes: 000 off, 001 right, 010 left, 011 hazard, 1xx same with brake. The datapath treats 111 as 011.
- Request decode (combinational), req_code:
  - hazard_req=1 or (left_req & right_req) -> 11
  - else left_req -> 10
  - else right_req -> 01
  - else 00
- Brake path: brake_q <= brake_req every cycle, independent of state. switch[2] = brake_q, giving 1 cycle latency.
- switch[1:0] = active_code (registered).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in SWEEP; held at 0 in IDLE.
  - step=1 exactly when count==TICK_DIV-1 in SWEEP; count then wraps to 0.
  - TICK_DIV=1 gives step=1 every SWEEP cycle.
- FSM states: IDLE, SWEEP.
- IDLE:
  - If req_code!=00: next cycle state=SWEEP, active_code<=req_code, phase=0, prescaler=0.
  - Else stay; active_code=00.
- SWEEP, on step:
  - Hazard preempt: if req_code==11 and active_code!=11, then active_code<=11 and phase<=0, at this step (not at wrap).
  - Else if phase==SWEEP_LEN-1 (wrap boundary): phase<=0.
    - req_code==00 -> state<=IDLE, active_code<=00.
    - Otherwise active_code<=req_code; a new direction commits here.
  - Else phase<=phase+1.
- SWEEP, no step: hold phase and active_code. Request changes between steps are ignored until the next step.
- Requests dropping mid-sweep: the sweep completes through phase SWEEP_LEN-1, then returns to IDLE at the wrap step.
- busy = (state==SWEEP), registered with state.
- Simultaneous events:
  - Hazard preempt at a wrap step: preempt wins, phase=0, code=11.
  - Brake is orthogonal to everything.
- Reset mid-sweep: immediate return to all reset values. The prescaler restarts from 0 after reset release.

Decomposition:
- Shared package tbird_pkg:
  - Mode-code constants MODE_OFF=3'b000, MODE_RIGHT=3'b001, MODE_LEFT=3'b010, MODE_HAZARD=3'b011, BRAKE_BIT=2.
  - FSM state encoding ST_IDLE=0, ST_SWEEP=1.
  - Both are reused by the lamp datapath and its bench.
- One sub-module: tbird_step_prescaler (TICK_DIV, DIV_W; ports clock, reset, run, step). It holds the counter and the step pulse.
- FSM, request decode and brake register stay in tbird_seq_ctrl.

Test Plan:
1. Assert reset with all requests at 0 -> switch=000, step=0, phase=0, busy=0. Reset held for 5 cycles with right_req=1 -> outputs stay at reset values.
2. TICK_DIV=4, SWEEP_LEN=5; right_req=1 from release -> next cycle busy=1, switch=001. step pulses every 4th cycle; phase sequence is 0,1,2,3,4,0 with switch constant 001.
3. Right sweep, switch to left_req only at phase 2 -> switch stays 001 through phase 4. At the wrap step switch=010 and phase=0.
4. Left sweep at phase 1, raise hazard_req -> at the next step switch=011 and phase=0 (not 2). Hold left_req & right_req with no hazard -> decoded as 011.
5. Idle, pulse brake_req high for 3 cycles -> switch=100 one cycle after rise, 000 one cycle after fall. During a right sweep the same pulse gives 101; phase and step are unaffected.
6. Right sweep, drop right_req at phase 3 -> phase 4 runs, then at the wrap step state=IDLE, switch=000, busy=0, step silent. Assert reset asynchronously mid-step-interval -> outputs clear before the next clock edge.
